// File: rtl/ascon_init_engine.sv
`default_nettype none
// ============================================================================
// Module   : ascon_init_engine
// Brief    : Ascon initialization sequencer; loads IV/key/nonce, drives an
//            external round unit for ROUNDS rounds, then applies key feed-forward.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_init_engine #(
    parameter int ROUNDS = 12,
    parameter int RPC    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         in_ready,
    input  logic [1:0]   sel_type,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    output logic [319:0] perm_s_i,
    output logic [3:0]   perm_rnd,
    input  logic [319:0] perm_s_o,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  x0,
    output logic [63:0]  x1,
    output logic [63:0]  x2,
    output logic [63:0]  x3,
    output logic [63:0]  x4
);

    localparam int         C_NUM_STEPS = ROUNDS / RPC;
    localparam logic [3:0] C_FIRST_RND = 4'(12 - ROUNDS);
    localparam logic [3:0] C_RPC       = 4'(RPC);
    localparam logic [3:0] C_LAST_CNT  = 4'(C_NUM_STEPS - 1);

    localparam logic [63:0] C_IV_AEAD128 = 64'h00001000808c0001;
    localparam logic [63:0] C_IV_HASH256 = 64'h0000080100cc0002;
    localparam logic [63:0] C_IV_XOF128  = 64'h0000080000cc0003;
    localparam logic [63:0] C_IV_CXOF128 = 64'h0000080000cc0004;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PERM = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_nxt;
    logic [319:0] r_state;
    logic [127:0] r_kreg;
    logic [3:0]   r_cnt;

    logic         w_last;
    logic         w_load_init;
    logic         w_load_perm;
    logic [63:0]  w_iv;
    logic [127:0] w_key_in;
    logic [127:0] w_nonce_in;
    logic [319:0] w_perm_next;

    assign w_last = (r_cnt == C_LAST_CNT);

    always_comb begin
        w_iv = C_IV_AEAD128;
        case (sel_type)
            2'b00:   w_iv = C_IV_AEAD128;
            2'b01:   w_iv = C_IV_HASH256;
            2'b10:   w_iv = C_IV_XOF128;
            default: w_iv = C_IV_CXOF128;
        endcase
    end

    // Key and nonce only take part in the AEAD mode; hash/XOF start from zero.
    assign w_key_in   = (sel_type == 2'b00) ? key   : 128'd0;
    assign w_nonce_in = (sel_type == 2'b00) ? nonce : 128'd0;

    // Final round result gets the key folded into x3/x4.
    assign w_perm_next = w_last ? (perm_s_o ^ {192'd0, r_kreg}) : perm_s_o;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_fsm_nxt = S_PERM;
                end
            end
            S_PERM: begin
                if (w_last) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        perm_rnd    = 4'd0;
        w_load_init = 1'b0;
        w_load_perm = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready    = 1'b1;
                w_load_init = start;
            end
            S_PERM: begin
                perm_rnd    = C_FIRST_RND + (r_cnt * C_RPC);
                w_load_perm = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= 320'd0;
            r_kreg  <= 128'd0;
            r_cnt   <= 4'd0;
        end else if (w_load_init) begin
            r_state <= {w_iv, w_key_in, w_nonce_in};
            r_kreg  <= w_key_in;
            r_cnt   <= 4'd0;
        end else if (w_load_perm) begin
            r_state <= w_perm_next;
            r_cnt   <= w_last ? 4'd0 : (r_cnt + 4'd1);
        end
    end

    assign perm_s_i = r_state;
    assign x0       = r_state[319:256];
    assign x1       = r_state[255:192];
    assign x2       = r_state[191:128];
    assign x3       = r_state[127:64];
    assign x4       = r_state[63:0];

endmodule
`default_nettype wire

// File: tb/tb_ascon_init_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_init_engine
// Brief    : Self-checking bench; three engine configurations with round stubs
//            and a scoreboard of expected initialized states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_init_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_a;
    logic         start_bc;
    logic         out_ready;
    logic [1:0]   sel_type;
    logic [127:0] key;
    logic [127:0] nonce;
    logic         use_ref;

    int n_checks = 0;
    int n_fail   = 0;

    // per-configuration outputs: 0 = defaults, 1 = RPC 4, 2 = ROUNDS 8 / RPC 2
    logic [319:0] si   [3];
    logic [319:0] so   [3];
    logic [3:0]   rnd  [3];
    logic         inr  [3];
    logic         vld  [3];
    logic [63:0]  w0 [3], w1 [3], w2 [3], w3 [3], w4 [3];
    logic [319:0] xs   [3];

    logic [319:0] q0[$];
    logic [319:0] q1[$];
    logic [319:0] q2[$];

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
        logic [3:0]  hi;
        {a0, a1, a2, a3, a4} = s;
        hi = 4'hf - r;
        a2 = a2 ^ {56'd0, hi, r};
        a0 = a0 ^ a4; a4 = a4 ^ a3; a2 = a2 ^ a1;
        t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
        a0 = a0 ^ t1; a1 = a1 ^ t2; a2 = a2 ^ t3; a3 = a3 ^ t4; a4 = a4 ^ t0;
        a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
        a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
        a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
        a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
        a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
        a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
        return {a0, a1, a2, a3, a4};
    endfunction

    // Software initialization: full p12 when rounds requested, identity otherwise.
    function automatic logic [319:0] init_model(input logic [1:0] sel, input logic [127:0] k,
                                                input logic [127:0] n, input bit rounds);
        logic [63:0]  iv;
        logic [127:0] kin, nin;
        logic [319:0] s;
        case (sel)
            2'b00:   iv = 64'h00001000808c0001;
            2'b01:   iv = 64'h0000080100cc0002;
            2'b10:   iv = 64'h0000080000cc0003;
            default: iv = 64'h0000080000cc0004;
        endcase
        kin = (sel == 2'b00) ? k : 128'd0;
        nin = (sel == 2'b00) ? n : 128'd0;
        s = {iv, kin, nin};
        if (rounds) begin
            for (int i = 0; i < 12; i++) s = ascon_round(s, 4'(i));
        end
        s[127:0] = s[127:0] ^ kin;
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign so[0] = use_ref ? ascon_round(si[0], rnd[0]) : si[0];
    assign so[1] = si[1];
    assign so[2] = si[2];

    ascon_init_engine u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_ready(inr[0]), .sel_type(sel_type),
        .key(key), .nonce(nonce), .perm_s_i(si[0]), .perm_rnd(rnd[0]), .perm_s_o(so[0]),
        .out_valid(vld[0]), .out_ready(out_ready),
        .x0(w0[0]), .x1(w1[0]), .x2(w2[0]), .x3(w3[0]), .x4(w4[0])
    );

    ascon_init_engine #(.ROUNDS(12), .RPC(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_bc), .in_ready(inr[1]), .sel_type(sel_type),
        .key(key), .nonce(nonce), .perm_s_i(si[1]), .perm_rnd(rnd[1]), .perm_s_o(so[1]),
        .out_valid(vld[1]), .out_ready(out_ready),
        .x0(w0[1]), .x1(w1[1]), .x2(w2[1]), .x3(w3[1]), .x4(w4[1])
    );

    ascon_init_engine #(.ROUNDS(8), .RPC(2)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_bc), .in_ready(inr[2]), .sel_type(sel_type),
        .key(key), .nonce(nonce), .perm_s_i(si[2]), .perm_rnd(rnd[2]), .perm_s_o(so[2]),
        .out_valid(vld[2]), .out_ready(out_ready),
        .x0(w0[2]), .x1(w1[2]), .x2(w2[2]), .x3(w3[2]), .x4(w4[2])
    );

    assign xs[0] = {w0[0], w1[0], w2[0], w3[0], w4[0]};
    assign xs[1] = {w0[1], w1[1], w2[1], w3[1], w4[1]};
    assign xs[2] = {w0[2], w1[2], w2[2], w3[2], w4[2]};

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] sb_front(input int d);
        if (d == 0) return (q0.size() > 0) ? q0[0] : 'x;
        if (d == 1) return (q1.size() > 0) ? q1[0] : 'x;
        return (q2.size() > 0) ? q2[0] : 'x;
    endfunction

    task automatic sb_pop(input int d);
        if (d == 0 && q0.size() > 0) void'(q0.pop_front());
        if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        if (d == 2 && q2.size() > 0) void'(q2.pop_front());
    endtask

    task automatic check_idle(input string tag, input int d);
        chk($sformatf("%s d%0d in_ready", tag, d), 320'(inr[d]), 320'd1);
        chk($sformatf("%s d%0d out_valid", tag, d), 320'(vld[d]), 320'd0);
        chk($sformatf("%s d%0d perm_rnd", tag, d), 320'(rnd[d]), 320'd0);
    endtask

    // One initialization on all three engines; stall holds out_ready low in
    // DONE (with stray starts to engine A), rst_at aborts engine A mid-PERM.
    task automatic run_op(input string tag, input logic [1:0] sel, input logic [127:0] k,
                          input logic [127:0] n, input logic [319:0] exp_a,
                          input logic [319:0] exp_bc, input int stall, input int rst_at);
        int lat  [3] = '{13, 4, 5};
        int nstp [3] = '{12, 3, 4};
        int first[3] = '{0, 0, 4};
        int step [3] = '{1, 4, 2};
        bit fin  [3] = '{1'b0, 1'b0, 1'b0};
        logic [3:0] er;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d ready before start", tag, d), 320'(inr[d]), 320'd1);
        end
        q0.push_back(exp_a);
        q1.push_back(exp_bc);
        q2.push_back(exp_bc);
        sel_type  = sel;
        key       = k;
        nonce     = n;
        start_a   = 1'b1;
        start_bc  = 1'b1;
        out_ready = (stall == 0);
        for (int c = 1; c <= 40 && !(fin[0] && fin[1] && fin[2]); c++) begin
            @(negedge clk);
            start_bc  = 1'b0;
            start_a   = (stall > 0) && (c == 3 || c == 14 || c == 13 + stall);
            sel_type  = 2'($urandom);
            key       = rand128();
            nonce     = rand128();
            out_ready = (stall == 0) || (c >= 13 + stall);
            rst       = (c == rst_at);
            if (rst_at > 0 && c == rst_at + 1) begin
                check_idle({tag, " after rst"}, 0);
                chk({tag, " after rst state"}, xs[0], 320'd0);
                sb_pop(0);
                fin[0] = 1'b1;
            end
            for (int d = 0; d < 3; d++) begin
                if (!fin[d]) begin
                    er = (c <= nstp[d]) ? 4'(first[d] + (c - 1) * step[d]) : 4'd0;
                    chk($sformatf("%s d%0d c%0d perm_rnd", tag, d, c), 320'(rnd[d]), 320'(er));
                    chk($sformatf("%s d%0d c%0d in_ready", tag, d, c), 320'(inr[d]), 320'd0);
                    if (c < lat[d]) begin
                        chk($sformatf("%s d%0d c%0d out_valid", tag, d, c), 320'(vld[d]), 320'd0);
                    end else begin
                        chk($sformatf("%s d%0d c%0d out_valid", tag, d, c), 320'(vld[d]), 320'd1);
                        chk($sformatf("%s d%0d c%0d state", tag, d, c), xs[d], sb_front(d));
                        if (out_ready) begin
                            sb_pop(d);
                            fin[d] = 1'b1;
                        end
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d completed in budget", tag, d), 320'(fin[d]), 320'd1);
        end
        @(negedge clk);
        start_a = 1'b0;
        rst     = 1'b0;
        for (int d = 0; d < 3; d++) check_idle({tag, " post"}, d);
    endtask

    initial begin
        logic [127:0] k, n;
        logic [319:0] ea;
        rst = 1'b1; start_a = 1'b0; start_bc = 1'b0; out_ready = 1'b1;
        sel_type = 2'b00; key = '0; nonce = '0; use_ref = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_idle("reset", d);
            chk($sformatf("reset d%0d state", d), xs[d], 320'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        k = 128'h000102030405060708090A0B0C0D0E0F;
        n = 128'h101112131415161718191A1B1C1D1E1F;
        ea = {64'h00001000808c0001, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'h1010101010101010, 64'h1010101010101010};
        run_op("aead_id", 2'b00, k, n, ea, init_model(2'b00, k, n, 1'b0), 0, 0);

        k = rand128(); n = rand128();
        run_op("hash_id", 2'b01, k, n, {64'h0000080100cc0002, 256'd0},
               {64'h0000080100cc0002, 256'd0}, 0, 0);
        run_op("xof_id", 2'b10, k, n, {64'h0000080000cc0003, 256'd0},
               {64'h0000080000cc0003, 256'd0}, 0, 0);
        run_op("cxof_id", 2'b11, k, n, {64'h0000080000cc0004, 256'd0},
               {64'h0000080000cc0004, 256'd0}, 0, 0);

        k = rand128(); n = rand128();
        run_op("stall", 2'b00, k, n, init_model(2'b00, k, n, 1'b0),
               init_model(2'b00, k, n, 1'b0), 5, 0);

        k = rand128(); n = rand128();
        run_op("abort", 2'b00, k, n, init_model(2'b00, k, n, 1'b0),
               init_model(2'b00, k, n, 1'b0), 0, 6);
        k = rand128(); n = rand128();
        run_op("after_abort", 2'b00, k, n, init_model(2'b00, k, n, 1'b0),
               init_model(2'b00, k, n, 1'b0), 0, 0);

        use_ref = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = rand128(); n = rand128();
            run_op($sformatf("ref%0d", i), 2'b00, k, n, init_model(2'b00, k, n, 1'b1),
                   init_model(2'b00, k, n, 1'b0), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
